// File: rtl/arb_grant_executor.sv
// rtl/arb_grant_executor.sv - executes one bus transfer per arbiter grant
//
// Captures the command of the requester selected by a one-hot grant, issues it
// as a single valid/ready transfer, reports done or timeout error per requester,
// then holds off for two cycles so the arbiter can observe the request drop.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   grant[1:0]                one-hot grant from arbiter (11 treated as 01)
//   req0_addr/wdata/we        requester 0 command
//   req1_addr/wdata/we        requester 1 command
//   bus_valid/addr/wdata/we   registered transfer request to shared resource
//   bus_ready, bus_rdata      resource handshake and read data
//   done[1:0], err[1:0]       one-cycle completion / timeout pulse per requester
//   rdata                     read data of last completed read
//   busy                      high whenever not idle
module arb_grant_executor #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        grant,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_we,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_FAIL,
        S_GAP
    } state_t;

    // Counter value at which an unanswered request gives up; bus_valid is then
    // held for exactly MAX_WAIT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q;
    logic [7:0]        wait_q;
    logic              gap_q;
    logic              owner_q;
    logic              bus_valid_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              bus_we_q;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            gap_q       <= 1'b0;
            owner_q     <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-armed below.
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant != 2'b00) begin
                        // grant[0] wins so the illegal 11 behaves as 01.
                        if (grant[0]) begin
                            owner_q     <= 1'b0;
                            bus_addr_q  <= req0_addr;
                            bus_wdata_q <= req0_wdata;
                            bus_we_q    <= req0_we;
                        end else begin
                            owner_q     <= 1'b1;
                            bus_addr_q  <= req1_addr;
                            bus_wdata_q <= req1_wdata;
                            bus_we_q    <= req1_we;
                        end
                        wait_q      <= '0;
                        bus_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Acceptance takes priority over timeout on the last cycle.
                    if (bus_ready) begin
                        if (!bus_we_q) begin
                            rdata_q <= bus_rdata;
                        end
                        bus_valid_q     <= 1'b0;
                        done_q[owner_q] <= 1'b1;
                        state_q         <= S_DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        bus_valid_q    <= 1'b0;
                        err_q[owner_q] <= 1'b1;
                        state_q        <= S_FAIL;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_DONE, S_FAIL: begin
                    gap_q   <= 1'b0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    // Two cycles with grant ignored: requester drop plus the
                    // arbiter's registered grant update.
                    if (gap_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= 1'b1;
                    end
                end
                default: begin
                    bus_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;

endmodule
